// File: rtl/dm_reader_pkg.sv
// Shared constants and state encoding for the DM read engine.
package dm_reader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_e;

endpackage

// File: rtl/dm_reader_if.sv
// DM access port plus valid/ready output stream of the DM read engine.
interface dm_reader_if
  import dm_reader_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);
  logic [AW-1:0] dm_addr;
  logic          dm_we;
  logic [DW-1:0] dm_din;
  logic [DW-1:0] dm_dout;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output dm_addr, dm_we, dm_din, out_data, out_valid,
    input  dm_dout, out_ready
  );

  modport slave (
    input  dm_addr, dm_we, dm_din, out_data, out_valid,
    output dm_dout, out_ready
  );
endinterface

// File: rtl/dm_reader_csum.sv
// Wrapping accumulator with synchronous clear; used for the transfer checksum.
module dm_reader_csum
  import dm_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] sum_o
);
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sum_q <= '0;
    else if (clr_i) sum_q <= '0;
    else if (en_i)  sum_q <= sum_q + din_i;
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/dm_reader.sv
// DM read engine: walks base..base+count-1 and streams words on valid/ready.
// Optional checksum output enabled by DM_READER_CSUM_EN.
module dm_reader
  import dm_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  dm_reader_if.master       bus
`ifdef DM_READER_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = base;
          rem_d   = count;
          state_d = (count != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        data_d  = bus.dm_dout;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          state_d = (rem_q == (ADDR_W+1)'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dm_addr   = ptr_q;
  assign bus.dm_we     = 1'b0;
  assign bus.dm_din    = '0;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;

`ifdef DM_READER_CSUM_EN
  logic csum_clr, csum_en;
  assign csum_clr = (state_q == IDLE) && start;
  assign csum_en  = (state_q == SEND) && bus.out_ready;

  dm_reader_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clr_i (csum_clr),
    .en_i  (csum_en),
    .din_i (data_q),
    .sum_o (csum)
  );
`endif
endmodule

// File: tb/tb_dm_reader.sv
// Scoreboard bench for dm_reader: directed transfers against a modelled DM image.
module tb_dm_reader;
  import dm_reader_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   count;
  logic              busy, done;
  logic              rdy;
  logic [DATA_W-1:0] mem [256];
`ifdef DM_READER_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  dm_reader_if #(.AW(ADDR_W), .DW(DATA_W)) bus ();

  dm_reader dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .base  (base),
    .count (count),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
`ifdef DM_READER_CSUM_EN
    ,
    .csum  (csum)
`endif
  );

  always #5 clk = ~clk;

  assign bus.dm_dout   = mem[bus.dm_addr];
  assign bus.out_ready = rdy;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   stall_cnt = 0;
  logic              hold_vld = 1'b0;
  logic [DATA_W-1:0] hold_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
    exp_t e;
    e.d = d;
    e.a = a;
    q.push_back(e);
  endtask

  // Monitor: handshakes pop the scoreboard; stalls must hold data stable.
  always @(negedge clk) begin
    if (reset) begin
      hold_vld = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (bus.out_valid) begin
        if (hold_vld) check("out_data stable", bus.out_data, hold_data);
        if (rdy) begin
          hold_vld = 1'b0;
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected word: got 0x%0h expected none", bus.out_data);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("out_data", bus.out_data, e.d);
            check("dm_addr", bus.dm_addr, e.a);
          end
        end else begin
          stall_cnt++;
          hold_vld  = 1'b1;
          hold_data = bus.out_data;
        end
      end else if (hold_vld) begin
        hold_vld = 1'b0;
        check("out_valid held", bus.out_valid, 1'b1);
      end
    end
  end

  task automatic run(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c,
                     input int exp_cyc, input string nm);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    base  = b;
    count = c;
    @(posedge clk);
    #1 start = 1'b0;
    check({nm, " busy"}, busy, 1'b1);
    cyc = 1;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({nm, " cycles to done"}, cyc, exp_cyc);
    @(posedge clk);
    #1;
    check({nm, " busy after done"}, busy, 1'b0);
    check({nm, " words left"}, q.size(), 0);
  endtask

  initial begin
    int d0, cyc;
    for (int unsigned i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
    mem[0]   = 16'h0127; mem[1] = 16'h0559; mem[2] = 16'h0059;
    mem[4]   = 16'h0102; mem[5] = 16'h0048;
    mem[8]   = 16'h10C3; mem[9] = 16'h00CD;
    mem[255] = 16'hBEEF;
    reset = 1'b1; start = 1'b0; base = '0; count = '0; rdy = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst out_data", bus.out_data, 16'h0000);
    check("rst dm_addr", bus.dm_addr, 8'h00);
    check("rst dm_we", bus.dm_we, 1'b0);
`ifdef DM_READER_CSUM_EN
    check("rst csum", csum, 16'h0000);
`endif
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // SORT image, full-speed
    push(16'h0127, 8'h00); push(16'h0559, 8'h01); push(16'h0059, 8'h02);
    run(8'h00, 9'd3, 7, "sort3");
`ifdef DM_READER_CSUM_EN
    check("sort3 csum", csum, 16'h06D9);
`endif

    // Backpressure on the first word
    stall_cnt = 0;
    rdy = 1'b0;
    push(16'h10C3, 8'h08); push(16'h00CD, 8'h09);
    fork
      begin
        repeat (5) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join_none
    run(8'h08, 9'd2, 8, "stall");
    check("stall cycles", stall_cnt, 3);
`ifdef DM_READER_CSUM_EN
    check("stall csum", csum, 16'h1190);
`endif

    // Address wrap
    push(16'hBEEF, 8'hFF); push(16'h0127, 8'h00);
    run(8'hFF, 9'd2, 5, "wrap");
    check("wrap ptr", bus.dm_addr, 8'h01);

    // Empty transfer
    d0 = done_cnt;
    run(8'h10, 9'd0, 1, "count0");
    check("count0 done pulses", done_cnt, d0 + 1);

    // Start while busy is ignored
    d0 = done_cnt;
    push(16'h0102, 8'h04); push(16'h0048, 8'h05);
    fork
      begin
        repeat (2) @(posedge clk);
        #1 begin start = 1'b1; base = 8'h00; count = 9'd3; end
        @(posedge clk);
        #1 start = 1'b0;
      end
    join_none
    run(8'h04, 9'd2, 5, "ignore");
    repeat (8) @(posedge clk);
    #1;
    check("ignore done pulses", done_cnt, d0 + 1);
    check("ignore idle", busy, 1'b0);

    // Reset while in SEND
    rdy = 1'b0;
    @(negedge clk);
    start = 1'b1; base = 8'h00; count = 9'd5;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("midrst reached SEND", bus.out_valid, 1'b1);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    check("midrst out_valid", bus.out_valid, 1'b0);
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst out_data", bus.out_data, 16'h0000);
    check("midrst dm_addr", bus.dm_addr, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst no done", done_cnt, d0);
    push(16'h0102, 8'h04); push(16'h0048, 8'h05);
    run(8'h04, 9'd2, 5, "after_rst");
`ifdef DM_READER_CSUM_EN
    check("after_rst csum", csum, 16'h014A);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
